// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Purpose  : SPI slave front-end: frame deserialiser, read-data serialiser.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
  parameter int PAYLOAD_W  = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 tx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int c_fw = PAYLOAD_W + 2;
  localparam int c_cw = $clog2(c_fw + 1);
  localparam int c_tw = $clog2(TX_TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_last_rx = c_cw'(c_fw - 1);
  localparam logic [c_cw-1:0] c_pw      = c_cw'(PAYLOAD_W);
  localparam logic [c_tw-1:0] c_last_to = c_tw'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX      = 3'd1,
    S_WAIT_TX = 3'd2,
    S_TX      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q;
  logic [c_cw-1:0]      cnt_q;
  logic [c_tw-1:0]      to_q;
  logic [c_fw-2:0]      rx_sr_q;
  logic [PAYLOAD_W-1:0] tx_sr_q;
  logic                 addr_seen_q;
  logic                 miso_q;
  logic [c_fw-1:0]      rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic [c_fw-1:0]      w_frame;
  logic                 w_abort;

  // Full frame as it stands once the current MOSI sample is appended.
  assign w_frame = {rx_sr_q, MOSI};
  assign w_abort = SS_n && (state_q == S_RX || state_q == S_WAIT_TX || state_q == S_TX);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      addr_seen_q <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      if (w_abort) begin
        // addr_seen survives an abort so the master can retry a read-data frame.
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        to_q        <= '0;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!SS_n) begin
              rx_sr_q <= {{(c_fw-2){1'b0}}, MOSI};
              cnt_q   <= c_cw'(1);
              state_q <= S_RX;
            end
          end
          S_RX: begin
            rx_sr_q <= w_frame[c_fw-2:0];
            if (cnt_q == c_last_rx) begin
              cnt_q <= '0;
              if (w_frame[c_fw-1] && w_frame[c_fw-2]) begin
                if (addr_seen_q) begin
                  rx_data_q  <= w_frame;
                  rx_valid_q <= 1'b1;
                  to_q       <= '0;
                  state_q    <= S_WAIT_TX;
                end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= S_DONE;
                end
              end else begin
                rx_data_q  <= w_frame;
                rx_valid_q <= 1'b1;
                if (w_frame[c_fw-1]) begin
                  addr_seen_q <= 1'b1;
                end
                state_q <= S_DONE;
              end
            end else begin
              cnt_q <= cnt_q + c_cw'(1);
            end
          end
          S_WAIT_TX: begin
            if (tx_valid) begin
              miso_q  <= tx_data[PAYLOAD_W-1];
              tx_sr_q <= tx_data << 1;
              cnt_q   <= c_cw'(1);
              state_q <= S_TX;
            end else if (to_q == c_last_to) begin
              frame_err_q <= 1'b1;
              addr_seen_q <= 1'b0;
              to_q        <= '0;
              state_q     <= S_DONE;
            end else begin
              to_q <= to_q + c_tw'(1);
            end
          end
          S_TX: begin
            if (cnt_q < c_pw) begin
              miso_q  <= tx_sr_q[PAYLOAD_W-1];
              tx_sr_q <= tx_sr_q << 1;
              cnt_q   <= cnt_q + c_cw'(1);
            end else begin
              cnt_q       <= '0;
              addr_seen_q <= 1'b0;
              state_q     <= S_DONE;
            end
          end
          S_DONE: begin
            if (SS_n) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Purpose  : Directed self-checking bench for spi_slave_param (PAYLOAD_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  spi_slave_param #(.PAYLOAD_W(8), .TX_TIMEOUT(16)) dut (
    .CLK(CLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_valid(tx_valid),
    .tx_data(tx_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) step(1'b0, f[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    n_checks++; if (MISO !== 1'b0) $display("FAIL reset_miso got %b exp 0", MISO); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 10'h000) $display("FAIL reset_rx_data got %h exp 000", rx_data); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_write;
    logic [9:0] f;
    f = 10'b00_1010_0101;
    for (int i = 9; i >= 1; i--) begin
      step(1'b0, f[i]);
      n_checks++; if (rx_valid !== 1'b0) $display("FAIL wr_early_valid bit %0d got %b exp 0", i, rx_valid); else n_pass++;
    end
    step(1'b0, f[0]);
    n_checks++; if (rx_valid !== 1'b1) $display("FAIL wr_valid got %b exp 1", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 10'h0A5) $display("FAIL wr_data got %h exp 0a5", rx_data); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL wr_err got %b exp 0", frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_done got %b exp 1", busy); else n_pass++;
    step(1'b1, 1'b0);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL wr_valid_pulse got %b exp 0", rx_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_read;
    logic [7:0] exp_bits;
    exp_bits = 8'hC3;
    send_frame(10'b10_0011_0000);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h230) $display("FAIL rd_addr got v=%b d=%h exp v=1 d=230", rx_valid, rx_data); else n_pass++;
    step(1'b1, 1'b0);
    send_frame(10'b11_0000_0000);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h300) $display("FAIL rd_cmd got v=%b d=%h exp v=1 d=300", rx_valid, rx_data); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rd_cmd_err got %b exp 0", frame_err); else n_pass++;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    n_checks++; if (MISO !== 1'b0 || busy !== 1'b1) $display("FAIL rd_wait got miso=%b busy=%b exp 0 1", MISO, busy); else n_pass++;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    n_checks++; if (MISO !== exp_bits[7]) $display("FAIL rd_miso bit 7 got %b exp %b", MISO, exp_bits[7]); else n_pass++;
    for (int b = 6; b >= 0; b--) begin
      step(1'b0, 1'b1);
      n_checks++; if (MISO !== exp_bits[b]) $display("FAIL rd_miso bit %0d got %b exp %b", b, MISO, exp_bits[b]); else n_pass++;
    end
    step(1'b0, 1'b1);
    n_checks++; if (MISO !== 1'b0) $display("FAIL rd_miso_after got %b exp 0", MISO); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rd_tx_err got %b exp 0", frame_err); else n_pass++;
    step(1'b1, 1'b0);
    send_frame(10'b11_0000_0000);
    n_checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL rd_repeat_err got e=%b v=%b exp e=1 v=0", frame_err, rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 10'h300) $display("FAIL rd_repeat_data got %h exp 300", rx_data); else n_pass++;
    step(1'b1, 1'b0);
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rd_err_pulse got %b exp 0", frame_err); else n_pass++;
  endtask

  task automatic test_read_no_addr;
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    send_frame(10'b11_1111_1111);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL noaddr_err got %b exp 1", frame_err); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL noaddr_valid got %b exp 0", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 10'h000) $display("FAIL noaddr_data got %h exp 000", rx_data); else n_pass++;
    step(1'b1, 1'b0);
    n_checks++; if (frame_err !== 1'b0 || busy !== 1'b0) $display("FAIL noaddr_after got e=%b busy=%b exp 0 0", frame_err, busy); else n_pass++;
  endtask

  task automatic test_abort;
    logic [9:0] f;
    f = 10'b01_1111_0000;
    for (int i = 9; i >= 5; i--) step(1'b0, f[i]);
    step(1'b1, 1'b0);
    n_checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL abort_err got e=%b v=%b exp e=1 v=0", frame_err, rx_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle got busy=%b exp 0", busy); else n_pass++;
    step(1'b0, f[9]);
    n_checks++; if (frame_err !== 1'b0) $display("FAIL abort_pulse got %b exp 0", frame_err); else n_pass++;
    for (int i = 8; i >= 0; i--) step(1'b0, f[i]);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h1F0) $display("FAIL abort_retry got v=%b d=%h exp v=1 d=1f0", rx_valid, rx_data); else n_pass++;
    step(1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    send_frame(10'b10_0000_0001);
    step(1'b1, 1'b0);
    send_frame(10'b11_0101_0101);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h355) $display("FAIL to_cmd got v=%b d=%h exp v=1 d=355", rx_valid, rx_data); else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0);
      if (k < 16) begin
        n_checks++; if (frame_err !== 1'b0 || MISO !== 1'b0) $display("FAIL to_wait cyc %0d got e=%b miso=%b exp 0 0", k, frame_err, MISO); else n_pass++;
      end else begin
        n_checks++; if (frame_err !== 1'b1 || MISO !== 1'b0) $display("FAIL to_expire got e=%b miso=%b exp 1 0", frame_err, MISO); else n_pass++;
      end
    end
    step(1'b1, 1'b0);
    send_frame(10'b11_0000_0000);
    n_checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL to_addr_cleared got e=%b v=%b exp 1 0", frame_err, rx_valid); else n_pass++;
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    send_frame(10'b10_0000_0010);
    step(1'b1, 1'b0);
    send_frame(10'b11_0000_0000);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    n_checks++; if (MISO !== exp_bits[7]) $display("FAIL rst_tx bit 7 got %b exp %b", MISO, exp_bits[7]); else n_pass++;
    for (int b = 6; b >= 4; b--) begin
      step(1'b0, 1'b0);
      n_checks++; if (MISO !== exp_bits[b]) $display("FAIL rst_tx bit %0d got %b exp %b", b, MISO, exp_bits[b]); else n_pass++;
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    n_checks++; if (MISO !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_mid_outs got miso=%b v=%b e=%b exp 0 0 0", MISO, rx_valid, frame_err); else n_pass++;
    n_checks++; if (rx_data !== 10'h000 || busy !== 1'b0) $display("FAIL rst_mid_state got d=%h busy=%b exp 000 0", rx_data, busy); else n_pass++;
    step(1'b1, 1'b0);
    send_frame(10'b11_0000_0000);
    n_checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL rst_mid_addr got e=%b v=%b exp 1 0", frame_err, rx_valid); else n_pass++;
    step(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_no_addr();
    test_abort();
    test_timeout();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the single-port RAM subsystem.
- Deserialises command frames of 2 command bits plus PAYLOAD_W payload bits from MOSI, and presents them to the RAM controller with a single-cycle rx_valid strobe.
- For read-data commands, waits (with timeout) for tx_valid/tx_data from the RAM and serialises PAYLOAD_W bits onto MISO, MSB first.
- Tracks read-address/read-data ordering, and flags protocol errors and aborts on frame_err.

Parameters:
- PAYLOAD_W, 8, payload bits per frame; frame width FW = PAYLOAD_W+2.
- TX_TIMEOUT, 16, maximum number of WAIT_TX cycles without tx_valid before error (≥1).

Ports:
- CLK  in  1  clock; serial bit clock, MOSI sampled and MISO updated on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out (registered).
- rx_data  out  PAYLOAD_W+2  received frame {cmd[1:0], payload}.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_valid  in  1  RAM read data valid.
- tx_data  in  PAYLOAD_W  RAM read data.
- frame_err  out  1  one-cycle strobe on protocol error/abort.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge CLK):
  - state=IDLE; MISO, rx_valid, rx_data, frame_err=0.
  - Internal bit counter, timeout counter, shift registers and addr_seen are cleared.
  - Reset has priority over everything, including mid-frame operation.
- States: IDLE, RX, WAIT_TX, TX, DONE.
- IDLE:
  - SS_n=0 at an edge: that edge samples MOSI as frame bit FW-1 (MSB), bit counter=1, go to RX.
  - SS_n=1: stay in IDLE.
- RX:
  - Each edge with SS_n=0 shifts MOSI into the LSB and increments the counter.
  - On the edge that samples bit 0 (the FW-th sample), decode cmd = frame[FW-1:FW-2]:
    - 00 (write address) / 01 (write data): rx_data<=frame, rx_valid<=1, go to DONE.
    - 10 (read address): rx_data<=frame, rx_valid<=1, addr_seen<=1, go to DONE. A repeated 10 overwrites the address; it is not an error.
    - 11 with addr_seen=1: rx_data<=frame, rx_valid<=1, timeout counter=0, go to WAIT_TX.
    - 11 with addr_seen=0: frame_err<=1, rx_valid stays 0, rx_data unchanged, go to DONE.
- rx_valid and frame_err are high for exactly one cycle and are never both high.
- WAIT_TX:
  - tx_valid=1 at an edge: MISO<=tx_data[PAYLOAD_W-1], shreg<=tx_data<<1, bit counter=1, go to TX.
  - tx_valid in any other state is ignored.
  - Otherwise increment the timeout counter. On reaching TX_TIMEOUT: frame_err<=1, addr_seen<=0, go to DONE.
- TX:
  - Each edge with counter<PAYLOAD_W: MISO<=shreg MSB, shift left, increment counter.
  - At counter==PAYLOAD_W: MISO<=0, addr_seen<=0, go to DONE.
  - Net effect: tx_data bit PAYLOAD_W-1..0 appears on MISO in consecutive cycles, starting the cycle after tx_valid is sampled.
- DONE: MOSI is ignored; MISO=0; return to IDLE on SS_n=1.
- SS_n=1 in RX, WAIT_TX or TX (abort):
  - Next state is IDLE; counters are cleared; MISO<=0; frame_err<=1 (single cycle); rx_valid stays 0.
  - addr_seen is retained, so the master may retry the 11 frame.
- SS_n=1 in IDLE or DONE: no error.
- MISO is 0 in every state except TX.

Test Plan:
- PAYLOAD_W=8, SS_n low for 10 bits 00_1010_0101 then high → rx_valid single pulse after the 10th edge with rx_data=0x0A5; frame_err=0; busy returns to 0 one cycle after SS_n rises.
- Frame 10_0011_0000 then frame 11_0000_0000; tx_valid with tx_data=0xC3 three cycles later → rx_valid pulses with 0x230 and 0x300; MISO=1,1,0,0,0,0,1,1 on the 8 cycles after tx_valid, then 0; a following 11 frame raises frame_err (addr_seen cleared).
- After reset, frame 11_1111_1111 → frame_err pulse, no rx_valid, rx_data stays 0.
- SS_n deasserted after 5 bits of a write frame → frame_err pulse, IDLE next cycle; the next full frame 01_1111_0000 → rx_data=0x1F0 correctly aligned.
- TX_TIMEOUT=16, valid read-address then 11 frame, no tx_valid → frame_err exactly 16 cycles after entering WAIT_TX; MISO stays 0; addr_seen cleared.
- rst_n low for one edge during TX (bit 3 of 0xA5) → all outputs 0 next cycle, state IDLE, addr_seen=0; a subsequent 11 frame → frame_err.
